// File: rtl/instr_buffer.sv
// Fetch-to-decode instruction buffer: compacts sparse fetch groups into a circular queue and presents the oldest DEC_W entries.
// Optional same-cycle bypass of an empty buffer is enabled by defining IBUF_BYPASS_EN.
module instr_buffer #(
  parameter int FETCH_W = 4,
  parameter int DEC_W   = 4,
  parameter int DEPTH   = 16,
  parameter int ILEN    = 32,
  parameter int XLEN    = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          fe_valid_i,
  output logic                          fe_ready_o,
  input  logic [FETCH_W*ILEN-1:0]       fe_instrs_i,
  input  logic [FETCH_W*XLEN-1:0]       fe_pcs_i,
  input  logic [FETCH_W-1:0]            fe_slot_valid_i,
  input  logic [FETCH_W*XLEN-1:0]       fe_pred_npc_i,
  output logic                          ibuf2dec_valid_o,
  input  logic                          dec2ibuf_ready_i,
  output logic [DEC_W*ILEN-1:0]         ibuf_instrs_o,
  output logic [DEC_W*XLEN-1:0]         ibuf_pcs_o,
  output logic [DEC_W-1:0]              ibuf_slot_valid_o,
  output logic [DEC_W*XLEN-1:0]         ibuf_pred_npc_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int FC_W  = $clog2(FETCH_W+1);

  logic [ILEN-1:0]  instr_mem [DEPTH];
  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [XLEN-1:0]  npc_mem   [DEPTH];

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic [FC_W-1:0]  rank [FETCH_W];
  logic [FC_W-1:0]  n_fe;
  logic [FC_W-1:0]  skip;
  logic [FC_W-1:0]  n_enq;
  logic [CNT_W-1:0] n_deq;
  logic             enq;
  logic             byp;
  logic [FC_W-1:0]  n_byp;
  logic [PTR_W-1:0] wr_idx [FETCH_W];
  logic [FETCH_W-1:0] wr_en;

  // rank[k] = number of valid slots below k, i.e. the compacted position of slot k
  always_comb begin
    n_fe = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      rank[k] = n_fe;
      n_fe    = n_fe + FC_W'(fe_slot_valid_i[k]);
    end
  end

  assign fe_ready_o = (count_q <= CNT_W'(DEPTH - FETCH_W));
  assign enq        = fe_valid_i & fe_ready_o;

`ifdef IBUF_BYPASS_EN
  assign byp   = (count_q == '0) && !flush_i;
  assign n_byp = (byp && fe_valid_i) ? n_fe : '0;
  always_comb begin
    skip = '0;
    if (byp && dec2ibuf_ready_i) begin
      if (int'(n_byp) > DEC_W) skip = FC_W'(DEC_W);
      else                     skip = n_byp;
    end
  end
`else
  assign byp   = 1'b0;
  assign n_byp = '0;
  assign skip  = '0;
`endif

  assign n_enq = enq ? (n_fe - skip) : '0;

  always_comb begin
    n_deq = '0;
    if ((count_q != '0) && dec2ibuf_ready_i)
      n_deq = (int'(count_q) > DEC_W) ? CNT_W'(DEC_W) : count_q;
  end

  // Slots taken by the bypass path are not stored; the remainder lands from tail onward
  always_comb begin
    for (int k = 0; k < FETCH_W; k++) begin
      wr_idx[k] = tail_q + PTR_W'(rank[k]) - PTR_W'(skip);
      wr_en[k]  = enq && fe_slot_valid_i[k] && (rank[k] >= skip);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (wr_en[k]) begin
        instr_mem[wr_idx[k]] <= fe_instrs_i[k*ILEN +: ILEN];
        pc_mem[wr_idx[k]]    <= fe_pcs_i[k*XLEN +: XLEN];
        npc_mem[wr_idx[k]]   <= fe_pred_npc_i[k*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(n_deq);
      tail_q  <= tail_q + PTR_W'(n_enq);
      count_q <= count_q + CNT_W'(n_enq) - n_deq;
    end
  end

  // Payload is masked by slot valid so empty slots read as zero
  always_comb begin
    ibuf_instrs_o     = '0;
    ibuf_pcs_o        = '0;
    ibuf_pred_npc_o   = '0;
    ibuf_slot_valid_o = '0;
    for (int i = 0; i < DEC_W; i++) begin
      if (byp) begin
        ibuf_slot_valid_o[i] = (i < int'(n_byp));
        for (int k = 0; k < FETCH_W; k++) begin
          if (fe_valid_i && fe_slot_valid_i[k] && (int'(rank[k]) == i)) begin
            ibuf_instrs_o[i*ILEN +: ILEN]   = fe_instrs_i[k*ILEN +: ILEN];
            ibuf_pcs_o[i*XLEN +: XLEN]      = fe_pcs_i[k*XLEN +: XLEN];
            ibuf_pred_npc_o[i*XLEN +: XLEN] = fe_pred_npc_i[k*XLEN +: XLEN];
          end
        end
      end else if (i < int'(count_q)) begin
        ibuf_slot_valid_o[i]            = 1'b1;
        ibuf_instrs_o[i*ILEN +: ILEN]   = instr_mem[head_q + PTR_W'(i)];
        ibuf_pcs_o[i*XLEN +: XLEN]      = pc_mem[head_q + PTR_W'(i)];
        ibuf_pred_npc_o[i*XLEN +: XLEN] = npc_mem[head_q + PTR_W'(i)];
      end
    end
  end

  assign ibuf2dec_valid_o = |ibuf_slot_valid_o;
  assign count_o          = count_q;

  a_full_not_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (count_q == CNT_W'(DEPTH)) |-> !fe_ready_o);
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CNT_W'(DEPTH));

endmodule
